// File: rtl/exibidor_sequencia_pkg.sv
// Shared definitions for the sequence player and other timed display blocks:
// state encoding, default on/off times and timer sizing.
package exibidor_sequencia_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    MOSTRA  = 3'd2,
    PAUSA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam int T_ON_PADRAO  = 1000;
  localparam int T_OFF_PADRAO = 500;

  // Counter must reach max(t_on, t_off)-1; keep at least one bit for the 1-cycle case.
  function automatic int largura_timer(input int t_on, input int t_off);
    int m;
    m = (t_on > t_off) ? t_on : t_off;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/exibidor_sequencia_registrador_n.sv
// Generic N-bit register with load enable and asynchronous active-high clear.
module registrador_n #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] dado_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dado_q <= '0;
    end else if (enable) begin
      dado_q <= d;
    end
  end

  assign q = dado_q;

endmodule

// File: rtl/exibidor_sequencia.sv
// Sequence player: on start, walks the sequence memory from address 0 to the
// captured last address, showing each code for T_ON cycles then a T_OFF blank gap.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 4,
  parameter int T_ON   = T_ON_PADRAO,
  parameter int T_OFF  = T_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] tamanho,
  input  logic [N-1:0]      dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [N-1:0]      leds,
  output logic              exibindo,
  output logic              pronto
);

  localparam int TW = largura_timer(T_ON, T_OFF);
  localparam logic [TW-1:0] FIM_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] FIM_OFF = TW'(T_OFF - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] ultimo_q;
  logic [N-1:0]      codigo_q;
  logic              captura;
  logic              carrega;

  registrador_n #(.N(ADDR_W)) u_ultimo (
    .clock  (clock),
    .clear  (clear),
    .enable (captura),
    .d      (tamanho),
    .q      (ultimo_q)
  );

  registrador_n #(.N(N)) u_codigo (
    .clock  (clock),
    .clear  (clear),
    .enable (carrega),
    .d      (dado),
    .q      (codigo_q)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    timer_d    = timer_q + TW'(1);
    captura    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        endereco_d = '0;
        timer_d    = '0;
        if (iniciar) begin
          captura  = 1'b1;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        timer_d  = '0;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        if (timer_q == FIM_ON) begin
          timer_d  = '0;
          estado_d = PAUSA;
        end
      end
      PAUSA: begin
        if (timer_q == FIM_OFF) begin
          timer_d = '0;
          // Last address ends the run, so the counter never wraps.
          if (endereco_q == ultimo_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + ADDR_W'(1);
            estado_d   = CARREGA;
          end
        end
      end
      FIM: begin
        timer_d    = '0;
        endereco_d = '0;
        estado_d   = OCIOSO;
      end
      default: begin
        timer_d    = '0;
        endereco_d = '0;
        estado_d   = OCIOSO;
      end
    endcase
  end

  assign carrega  = (estado_q == CARREGA);
  assign endereco = endereco_q;
  assign leds     = (estado_q == MOSTRA) ? codigo_q : '0;
  assign exibindo = (estado_q != OCIOSO);
  assign pronto   = (estado_q == FIM);

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Scoreboard bench: each start pushes the per-cycle expected outputs derived from
// the playback timing rules; a negedge monitor pops and compares every cycle.
module tb_exibidor_sequencia;

  localparam int TON  = 3;
  localparam int TOFF = 2;
  localparam int P    = 1 + TON + TOFF;

  logic       clock = 1'b0;
  logic       clear;
  logic       iniciar;
  logic [3:0] tamanho;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;

  always #5 clock = ~clock;

  exibidor_sequencia #(
    .N      (4),
    .ADDR_W (4),
    .T_ON   (TON),
    .T_OFF  (TOFF)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .iniciar  (iniciar),
    .tamanho  (tamanho),
    .dado     (dado),
    .endereco (endereco),
    .leds     (leds),
    .exibindo (exibindo),
    .pronto   (pronto)
  );

  logic [3:0] mem [16];
  assign dado = mem[endereco];

  typedef struct packed {
    logic [3:0] ender;
    logic [3:0] leds;
    logic       exib;
    logic       pronto;
  } saida_t;

  saida_t esperado[$];
  saida_t e_mon;
  int     vetores = 0;
  int     erros   = 0;
  bit     mon_en  = 1'b0;

  task automatic comparar(input string nome, input saida_t obt, input saida_t exp);
    vetores++;
    if (obt !== exp) begin
      erros++;
      $display("FAIL %s t=%0t: got endereco=%0d leds=%0d exibindo=%0b pronto=%0b, want endereco=%0d leds=%0d exibindo=%0b pronto=%0b",
               nome, $time, obt.ender, obt.leds, obt.exib, obt.pronto,
               exp.ender, exp.leds, exp.exib, exp.pronto);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (esperado.size() > 0) e_mon = esperado.pop_front();
      else                     e_mon = '0;
      comparar("ciclo", {endereco, leds, exibindo, pronto}, e_mon);
    end
  end

  // Expected trace: the idle cycle where the start is sampled, then per address
  // one load cycle, TON cycles showing the code, TOFF blank cycles, then one done cycle.
  task automatic prever(input int ult);
    esperado.push_back('0);
    for (int a = 0; a <= ult; a++) begin
      esperado.push_back({4'(a), 4'd0, 1'b1, 1'b0});
      repeat (TON)  esperado.push_back({4'(a), mem[a], 1'b1, 1'b0});
      repeat (TOFF) esperado.push_back({4'(a), 4'd0, 1'b1, 1'b0});
    end
    esperado.push_back({4'(ult), 4'd0, 1'b1, 1'b1});
  endtask

  task automatic tocar(input int ult, input bit ruido);
    @(posedge clock); #1;
    tamanho = 4'(ult);
    prever(ult);
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    for (int c = 2; c <= 1 + (ult + 1) * P; c++) begin
      @(posedge clock); #1;
      if (ruido) begin
        iniciar = 1'($urandom);
        tamanho = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      end
    end
    @(posedge clock); #1;
    iniciar = 1'b0;
    tamanho = 4'($urandom);
  endtask

  task automatic mem_potencias();
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal;
  end

  initial begin
    clear   = 1'b0;
    iniciar = 1'b0;
    tamanho = 4'd0;
    mem_potencias();

    #8 clear = 1'b1;
    #1 comparar("reset_async", {endereco, leds, exibindo, pronto}, '0);
    #3 clear = 1'b0;
    mon_en = 1'b1;

    // No start request: outputs must stay idle while tamanho moves.
    repeat (5) begin
      @(posedge clock); #1;
      tamanho = 4'($urandom);
    end

    tocar(3, 1'b0);

    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    mem[0] = 4'd5;
    tocar(0, 1'b0);

    mem_potencias();
    tocar(3, 1'b1);

    // Abort during the second code's display.
    @(posedge clock); #1;
    tamanho = 4'd3;
    prever(3);
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    comparar("antes_clear", {endereco, leds, exibindo, pronto}, {4'd1, 4'd2, 1'b1, 1'b0});
    clear = 1'b1;
    esperado.delete();
    #1 comparar("clear_async", {endereco, leds, exibindo, pronto}, '0);
    @(negedge clock); #2;
    clear = 1'b0;
    tocar(3, 1'b0);

    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    tocar(15, 1'b0);

    repeat (10) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      tocar($urandom_range(0, 15), 1'($urandom));
    end

    repeat (3) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/exibidor_sequencia.md
# exibidor_sequencia

Sequence player for the AstroGenius game: on a start pulse it reads stored N-bit codes from an external sequence memory, starting at address 0 and ending at a chosen last address. Each code is shown on the LED outputs for a fixed on-time, followed by a blank gap. It is the read side of the sequence storage that the player's inputs are registered into. It sits between the sequence memory and the LED/display drivers and is commanded by the game's main control unit.

## Interface
- N, 4, width of one stored code / LED bus
- ADDR_W, 4, memory address width; maximum sequence length 2^ADDR_W
- T_ON, 1000, clock cycles a code is shown (≥1)
- T_OFF, 500, clock cycles of blank gap after each code (≥1)

- clock  in  1  single system clock, rising edge
- clear  in  1  reset, asynchronous and active-high
- iniciar  in  1  start request, sampled only in OCIOSO
- tamanho  in  ADDR_W  last address to play (sequence length − 1), captured on start
- dado  in  N  memory read data; combinational read of `endereco`
- endereco  out  ADDR_W  memory address being played
- leds  out  N  displayed code; 0 when blank
- exibindo  out  1  high whenever the FSM is not in OCIOSO
- pronto  out  1  one-cycle done pulse

## Operation
- States:
  - OCIOSO: `endereco`=0, `leds`=0. `iniciar`=1 → CARREGA; capture `tamanho` into an internal `ultimo` register.
  - CARREGA (1 cycle): latch `dado` into the display register, clear the timer → MOSTRA.
  - MOSTRA: `leds` = latched code for T_ON cycles → PAUSA, clear the timer.
  - PAUSA: `leds`=0 for T_OFF cycles. At the end: if `endereco`==`ultimo` → FIM; else `endereco`+1 → CARREGA.
  - FIM (1 cycle): `pronto`=1 → OCIOSO, `endereco`=0.
- Timer width is clog2(max(T_ON,T_OFF)). Timer reaches terminal at count−1.
- `endereco` never wraps during play. `ultimo` = 2^ADDR_W − 1 plays every address, then goes to FIM.
- A code value of 0 is still timed normally; `leds` stays 0 during its MOSTRA.
- `iniciar` is ignored in every state except OCIOSO; this includes FIM.
- Changes on `tamanho` after capture are ignored.
- `clear` at any time: FSM → OCIOSO; `endereco`, `leds`, timer, `ultimo` and the display register go to 0. This is immediate and asynchronous.

## Timing
- Reset values: `endereco`=0, `leds`=0, `exibindo`=0, `pronto`=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Start: `iniciar` is sampled at edge 0; CARREGA is the state during cycle 1.
- `dado` is captured at the end of CARREGA. `leds` are valid from the following cycle for exactly T_ON cycles, then 0 for T_OFF cycles.
- Period per code: P = 1 + T_ON + T_OFF cycles.
- With L = `ultimo`+1, FIM (`pronto`=1) is the state during cycle 1 + L·P. OCIOSO follows in the next cycle, where a new `iniciar` is accepted.
- `endereco` changes on the edge entering CARREGA. Memory data must settle within that cycle.

## Structure
- Shared package/include file holds:
  - State encoding localparams (OCIOSO, CARREGA, MOSTRA, PAUSA, FIM).
  - Default T_ON/T_OFF constants, reused by other timed display blocks.
- Sub-modules:
  - Existing `registrador_n` (N bits): display register, enable = CARREGA, clear = `clear`.
  - Second `registrador_n` (ADDR_W bits): `ultimo`.
- Address counter, timer and FSM stay local.

## Test plan
All scenarios use N=4, ADDR_W=4, T_ON=3, T_OFF=2 (P=6).
- Reset: pulse `clear` mid-cycle → all outputs 0 immediately; nothing happens without `iniciar`.
- Memory {1,2,4,8}, `tamanho`=3, `iniciar` at edge 0:
  - `leds` pattern 1,1,1,0,0 then 2…, 4…, 8….
  - `endereco` steps 0→1→2→3.
  - `pronto` high only in cycle 25, with `exibindo` high in cycles 1–25.
- `tamanho`=0, memory[0]=5 → `leds`=5 in cycles 2–4, `pronto` in cycle 7.
- During play, pulse `iniciar` and change `tamanho` to 0 → no restart, and playback still covers all 4 addresses.
- Assert `clear` during the second MOSTRA (`leds`=2) → `leds`=0 and `endereco`=0 asynchronously. A new `iniciar` then restarts from address 0.
- `tamanho`=15, memory = address value → addresses 0..15 with no wrap, `leds` 0..15, `pronto` in cycle 97.
